// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID pipeline register, redirect/stall handling
// and a halt state entered when the halt encoding is fetched.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0]        RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [5:0]         imem_a,
    input  logic [INSTR_W-1:0] imem_rd,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc_plus4,
    output logic               if_valid,
    output logic               halted,
    output logic               misalign,
    output logic [31:0]        fetch_count
);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [31:0]        if_pc_q, if_pc_d;
    logic [31:0]        if_pc_plus4_q, if_pc_plus4_d;
    logic               if_valid_q, if_valid_d;
    logic               misalign_q, misalign_d;
    logic [31:0]        fetch_count_q, fetch_count_d;

    logic               is_halt_word;
    logic [31:0]        pc_plus4;

    assign is_halt_word = (imem_rd == HALT_WORD);
    assign pc_plus4     = pc_q + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
            if_valid_q    <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_valid_q    <= if_valid_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Redirect outranks stall; a halt word is only recognised on a real capture slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (!redirect_valid && !stall && is_halt_word) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_valid_d    = if_valid_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d       = {redirect_pc[31:2], 2'b00};
                    if_valid_d = 1'b0;
                    if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
                end else if (!stall) begin
                    if (is_halt_word) begin
                        if_valid_d = 1'b0;
                    end else begin
                        pc_d          = pc_plus4;
                        if_instr_d    = imem_rd;
                        if_pc_d       = pc_q;
                        if_pc_plus4_d = pc_plus4;
                        if_valid_d    = 1'b1;
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
                end
            end
            default: if_valid_d = 1'b0;
        endcase
    end

    assign imem_a      = pc_q[7:2];
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_valid    = if_valid_q;
    assign halted      = (state_q == ST_HALT);
    assign misalign    = misalign_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect traffic against a behavioural fetch model.
module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [5:0]  imem_a;
    logic [31:0] imem_rd;
    logic [31:0] if_instr, if_pc, if_pc_plus4, fetch_count;
    logic        if_valid, halted, misalign;

    logic [31:0] mem [64];

    // Model state
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
    logic        m_valid, m_halt, m_mis;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_a(imem_a), .imem_rd(imem_rd),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .if_valid(if_valid), .halted(halted), .misalign(misalign),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;
    assign imem_rd = mem[imem_a];

    task automatic fill_mem(input int halt_one_in);
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT) mem[i] = 32'h0000_0013;
            if (halt_one_in > 0 && $urandom_range(halt_one_in - 1) == 0) mem[i] = HALT;
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_cnt = 0;
        m_valid = 0; m_halt = 0; m_mis = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        stall = 0; redirect_valid = 0; redirect_pc = 0;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, and step to just after the edge.
    task automatic tick(input logic st, input logic rv, input logic [31:0] rpc);
        logic [31:0] w;
        stall = st; redirect_valid = rv; redirect_pc = rpc;
        if (!m_halt) begin
            if (rv) begin
                if (rpc % 4 != 0) m_mis = 1;
                m_pc = rpc - (rpc % 4);
                m_valid = 0;
            end else if (!st) begin
                w = mem[(m_pc / 4) % 64];
                if (w == HALT) begin
                    m_halt = 1;
                    m_valid = 0;
                end else begin
                    m_instr = w; m_ipc = m_pc; m_ipc4 = m_pc + 4;
                    m_pc = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
                end
            end
        end
        @(posedge clk); #1;
        stall = 0; redirect_valid = 0;
    endtask

    task automatic test_reset();
        fill_mem(0);
        apply_reset();
        checks++;
        if (if_valid !== 1'b0 || halted !== 1'b0 || misalign !== 1'b0 || fetch_count !== 32'd0 ||
            if_pc !== 32'd0 || if_instr !== 32'd0 || if_pc_plus4 !== 32'd0 || imem_a !== 6'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b halted=%b mis=%b cnt=%0d pc=%h instr=%h pc4=%h a=%0d, required all zero",
                     if_valid, halted, misalign, fetch_count, if_pc, if_instr, if_pc_plus4, imem_a);
        end
        tick(0, 1, 32'h0000_0022);
        tick(0, 0, 0);
        // Asynchronous assertion mid-cycle must clear state without a clock edge.
        #3 reset = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b0 || misalign !== 1'b0 || fetch_count !== 32'd0 || imem_a !== 6'd0 || if_pc !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b mis=%b cnt=%0d a=%0d pc=%h, required 0 0 0 0 0",
                     if_valid, misalign, fetch_count, imem_a, if_pc);
        end
        @(negedge clk);
        apply_reset();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        fill_mem(0);
        mem[0] = 32'h0010_0093; mem[1] = 32'h0020_0113;
        mem[2] = 32'h0030_0193; mem[3] = 32'h0020_81B3;
        apply_reset();
        checks++;
        if (if_valid !== 1'b0) begin
            errors++; $display("FAIL seq_cycle0_valid: got %b, required 0", if_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0);
            exp_pc = 32'(i * 4);
            checks++;
            if (if_pc !== exp_pc || if_valid !== 1'b1 || if_instr !== mem[i] || if_pc_plus4 !== exp_pc + 4) begin
                errors++;
                $display("FAIL seq_fetch%0d: pc=%h valid=%b instr=%h pc4=%h, required %h 1 %h %h",
                         i, if_pc, if_valid, if_instr, if_pc_plus4, exp_pc, mem[i], exp_pc + 4);
            end
        end
        checks++;
        if (fetch_count !== 32'd4) begin
            errors++; $display("FAIL seq_count: got %0d, required 4", fetch_count);
        end
    endtask

    task automatic test_stall();
        fill_mem(0);
        apply_reset();
        tick(0, 0, 0);
        tick(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0);
            checks++;
            if (if_pc !== 32'd4 || imem_a !== 6'd2 || fetch_count !== 32'd2 || if_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: pc=%h a=%0d cnt=%0d valid=%b, required 4 2 2 1",
                         i, if_pc, imem_a, fetch_count, if_valid);
            end
        end
        tick(0, 0, 0);
        checks++;
        if (if_pc !== 32'd8 || fetch_count !== 32'd3) begin
            errors++; $display("FAIL stall_release: pc=%h cnt=%0d, required 8 3", if_pc, fetch_count);
        end
    endtask

    task automatic test_redirect_stall();
        tick(1, 1, 32'h38);
        checks++;
        if (if_valid !== 1'b0 || imem_a !== 6'd14) begin
            errors++; $display("FAIL redir_flush: valid=%b a=%0d, required 0 14", if_valid, imem_a);
        end
        tick(0, 0, 0);
        checks++;
        if (if_pc !== 32'h38 || if_valid !== 1'b1 || if_instr !== mem[14]) begin
            errors++; $display("FAIL redir_target: pc=%h valid=%b instr=%h, required 38 1 %h",
                               if_pc, if_valid, if_instr, mem[14]);
        end
    endtask

    task automatic test_misalign();
        tick(0, 1, 32'h6);
        checks++;
        if (misalign !== 1'b1 || imem_a !== 6'd1) begin
            errors++; $display("FAIL misalign_set: mis=%b a=%0d, required 1 1", misalign, imem_a);
        end
        tick(0, 0, 0);
        tick(0, 1, 32'h10);
        tick(0, 0, 0);
        checks++;
        if (misalign !== 1'b1 || if_pc !== 32'h10) begin
            errors++; $display("FAIL misalign_sticky: mis=%b pc=%h, required 1 10", misalign, if_pc);
        end
    endtask

    task automatic test_wrap();
        tick(0, 1, 32'hFC);
        checks++;
        if (imem_a !== 6'd63) begin
            errors++; $display("FAIL wrap_63: a=%0d, required 63", imem_a);
        end
        tick(0, 0, 0);
        checks++;
        if (imem_a !== 6'd0 || if_pc !== 32'hFC || if_pc_plus4 !== 32'h100) begin
            errors++; $display("FAIL wrap_0: a=%0d pc=%h pc4=%h, required 0 fc 100", imem_a, if_pc, if_pc_plus4);
        end
    endtask

    task automatic test_halt();
        logic [31:0] cnt0;
        mem[18] = HALT;
        tick(0, 1, 32'h48);
        cnt0 = m_cnt;
        tick(0, 0, 0);
        checks++;
        if (halted !== 1'b1 || if_valid !== 1'b0 || imem_a !== 6'd18) begin
            errors++; $display("FAIL halt_enter: halted=%b valid=%b a=%0d, required 1 0 18", halted, if_valid, imem_a);
        end
        tick(0, 1, 32'h0);
        tick(1, 0, 0);
        tick(0, 0, 0);
        checks++;
        if (halted !== 1'b1 || imem_a !== 6'd18 || fetch_count !== cnt0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL halt_frozen: halted=%b a=%0d cnt=%0d valid=%b, required 1 18 %0d 0",
                               halted, imem_a, fetch_count, if_valid, cnt0);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || imem_a !== 6'd0 || fetch_count !== 32'd0) begin
            errors++; $display("FAIL halt_reset: halted=%b a=%0d cnt=%0d, required 0 0 0", halted, imem_a, fetch_count);
        end
        @(negedge clk);
        apply_reset();
        tick(0, 0, 0);
        checks++;
        if (if_pc !== 32'd0 || if_valid !== 1'b1) begin
            errors++; $display("FAIL halt_refetch: pc=%h valid=%b, required 0 1", if_pc, if_valid);
        end
    endtask

    task automatic test_random();
        logic        st, rv;
        logic [31:0] rpc;
        fill_mem(40);
        mem[0] = 32'h0000_0013;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            if (m_halt && $urandom_range(9) == 0) begin
                apply_reset();
                continue;
            end
            st  = ($urandom_range(3) == 0);
            rv  = ($urandom_range(9) == 0);
            rpc = $urandom;
            tick(st, rv, rpc);
            checks++;
            if (imem_a !== m_pc[7:2] || if_instr !== m_instr || if_pc !== m_ipc || if_pc_plus4 !== m_ipc4 ||
                if_valid !== m_valid || halted !== m_halt || misalign !== m_mis || fetch_count !== m_cnt) begin
                errors++;
                $display("FAIL random_cyc%0d: a=%0d instr=%h pc=%h pc4=%h v=%b h=%b m=%b cnt=%0d, required a=%0d instr=%h pc=%h pc4=%h v=%b h=%b m=%b cnt=%0d",
                         n, imem_a, if_instr, if_pc, if_pc_plus4, if_valid, halted, misalign, fetch_count,
                         m_pc[7:2], m_instr, m_ipc, m_ipc4, m_valid, m_halt, m_mis, m_cnt);
            end
        end
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_wrap();
        test_halt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
